fetch_queue: RTL and testbench

Instruction queue between the fetch stage and decode. Captures fetch's `{pc, pc_plus4, instr}` tuple each accepted cycle into a small FIFO and presents the oldest entry to decode with a valid/ready handshake. Decouples decode stalls from fetch and drops all in-flight wrong-path instructions when execute redirects the PC.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fq_mem.sv | 38 +++
 rtl/fetch_queue.sv | 134 +++++++++++++
 tb/tb_fetch_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the front end of the pipeline.
//   NOP_INSTR   : canonical RISC-V NOP (addi x0, x0, 0), shown to decode
//                 whenever no real instruction is available.
//   FQ_ENTRY_W  : packed fetch-queue entry width for the default 32-bit
//                 PC / instruction configuration, laid out {pc, pc_plus4, instr}.
//   fq_entry_w(): same width computed for arbitrary PC / instruction widths.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int FQ_DEF_ADDRESS_WIDTH = 32;
    localparam int FQ_DEF_DATA_WIDTH    = 32;
    localparam int FQ_ENTRY_W           = 2 * FQ_DEF_ADDRESS_WIDTH + FQ_DEF_DATA_WIDTH;

    function automatic int fq_entry_w(input int address_width, input int data_width);
        return 2 * address_width + data_width;
    endfunction

endpackage : riscv_pkg

// File: rtl/fq_mem.sv
// ---------------------------------------------------------------------------
// fq_mem
// Storage array for the fetch queue: DEPTH x WIDTH registers, one synchronous
// write port and one combinational (asynchronous) read port. The array has
// no reset; validity of each slot is tracked by the owner's pointers/count.
//
// Ports
//   clk   : in  1      rising-edge clock for the write port
//   we    : in  1      write enable
//   waddr : in  AW     write slot
//   wdata : in  WIDTH  write data
//   raddr : in  AW     read slot
//   rdata : out WIDTH  contents of slot raddr (same cycle)
// ---------------------------------------------------------------------------
module fq_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fq_mem

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction queue between fetch and decode. Each accepted fetch cycle the
// {pc, pc_plus4, instr} tuple is written into a DEPTH-entry circular buffer;
// the oldest entry is presented to decode behind a valid/ready handshake.
// A flush (execute redirect) discards every queued entry on the next edge.
//
// Ports
//   clk         : in  1              rising-edge clock
//   rst         : in  1              asynchronous, active-low reset
//   valid_f     : in  1              fetch offers a tuple
//   pc_f        : in  ADDRESS_WIDTH  fetched PC
//   pc_plus4_f  : in  ADDRESS_WIDTH  fetched PC + 4
//   instr_f     : in  DATA_WIDTH     fetched instruction
//   ready_f     : out 1              queue can accept (not full)
//   flush       : in  1              redirect: drop all entries
//   valid_d     : out 1              head entry valid (not empty)
//   ready_d     : in  1              decode takes the head entry
//   pc_d        : out ADDRESS_WIDTH  head PC            (0 when empty)
//   pc_plus4_d  : out ADDRESS_WIDTH  head PC + 4        (0 when empty)
//   instr_d     : out DATA_WIDTH     head instruction   (NOP when empty)
//   count       : out clog2(DEPTH)+1 occupied entries
// ---------------------------------------------------------------------------
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_f,
    input  logic [ADDRESS_WIDTH-1:0]   pc_f,
    input  logic [ADDRESS_WIDTH-1:0]   pc_plus4_f,
    input  logic [DATA_WIDTH-1:0]      instr_f,
    output logic                       ready_f,
    input  logic                       flush,
    output logic                       valid_d,
    input  logic                       ready_d,
    output logic [ADDRESS_WIDTH-1:0]   pc_d,
    output logic [ADDRESS_WIDTH-1:0]   pc_plus4_d,
    output logic [DATA_WIDTH-1:0]      instr_d,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = fq_entry_w(ADDRESS_WIDTH, DATA_WIDTH);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;

    // Full/empty come only from registered occupancy, so ready_f has no
    // combinational dependence on ready_d: a full queue refuses a push even
    // when decode pops in the same cycle.
    assign ready_f = (count_q != FULL_CNT);
    assign valid_d = (count_q != '0);
    assign count   = count_q;

    assign push = valid_f && ready_f && !flush;
    assign pop  = valid_d && ready_d && !flush;

    assign wdata = {pc_f, pc_plus4_f, instr_f};

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fq_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Empty queue shows a harmless bubble rather than stale array contents.
    always_comb begin
        pc_d       = '0;
        pc_plus4_d = '0;
        instr_d    = DATA_WIDTH'(NOP_INSTR);
        if (valid_d) begin
            pc_d       = rdata[ENTRY_W-1 -: ADDRESS_WIDTH];
            pc_plus4_d = rdata[DATA_WIDTH +: ADDRESS_WIDTH];
            instr_d    = rdata[DATA_WIDTH-1:0];
        end
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        valid_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [31:0] instr_f;
    logic        ready_f;
    logic        flush;
    logic        valid_d;
    logic        ready_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [31:0] instr_d;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    entry_t mq[$];

    fetch_queue #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .DEPTH         (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_f    (valid_f),
        .pc_f       (pc_f),
        .pc_plus4_f (pc_plus4_f),
        .instr_f    (instr_f),
        .ready_f    (ready_f),
        .flush      (flush),
        .valid_d    (valid_d),
        .ready_d    (ready_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .instr_d    (instr_d),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".count"},   32'(count),   32'(sz));
        chk({tag, ".valid_d"}, 32'(valid_d), 32'(sz != 0));
        chk({tag, ".ready_f"}, 32'(ready_f), 32'(sz != DEPTH));
        chk({tag, ".pc_d"},       pc_d,       (sz != 0) ? mq[0].pc    : 32'h0);
        chk({tag, ".pc_plus4_d"}, pc_plus4_d, (sz != 0) ? mq[0].pc4   : 32'h0);
        chk({tag, ".instr_d"},    instr_d,    (sz != 0) ? mq[0].instr : NOP);
    endtask

    // One clock: model applies the rules to the inputs held across the edge,
    // then outputs are compared at the following falling edge.
    task automatic tick(input string tag);
        bit     do_push;
        bit     do_pop;
        entry_t e;
        @(posedge clk);
        do_push = valid_f && (mq.size() < DEPTH) && !flush;
        do_pop  = (mq.size() > 0) && ready_d && !flush;
        e.pc    = pc_f;
        e.pc4   = pc_plus4_f;
        e.instr = instr_f;
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rd, input logic fl);
        valid_f    = v;
        pc_f       = pc;
        pc_plus4_f = pc + 32'd4;
        instr_f    = ins;
        ready_d    = rd;
        flush      = fl;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset state, before any clock edge
        #2;
        chk("rst.count",   32'(count),   32'd0);
        chk("rst.valid_d", 32'(valid_d), 32'd0);
        chk("rst.ready_f", 32'(ready_f), 32'd1);
        chk("rst.pc_d",    pc_d,         32'h0);
        chk("rst.pc4_d",   pc_plus4_d,   32'h0);
        chk("rst.instr_d", instr_d,      NOP);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Fill with no pops
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 32'(8'h11 * (i + 1)), 1'b0, 1'b0);
            tick("fill");
            chk("fill.count", 32'(count), 32'(i + 1));
        end
        chk("fill.ready_f_full", 32'(ready_f), 32'd0);
        drive(1'b1, 32'h10, 32'h55, 1'b0, 1'b0);
        tick("fill5");
        chk("fill5.count", 32'(count), 32'd4);
        chk("fill5.head",  pc_d,       32'h0);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            chk("drain.pc_d", pc_d, 32'(i * 4));
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            tick("drain");
        end
        chk("drain.valid_d", 32'(valid_d), 32'd0);
        chk("drain.instr_d", instr_d,      NOP);

        // Streaming through the pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 32'($urandom), 1'b1, 1'b0);
            tick("stream");
            chk("stream.count", 32'(count), 32'd1);
            chk("stream.pc_d",  pc_d,       32'h100 + 32'(i * 4));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick("stream_end");

        // Simultaneous push/pop when full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 32'($urandom), 1'b0, 1'b0);
            tick("full_fill");
        end
        drive(1'b1, 32'h300, 32'h77, 1'b1, 1'b0);
        tick("full_pp");
        chk("full_pp.count",   32'(count),   32'd3);
        chk("full_pp.ready_f", 32'(ready_f), 32'd1);
        chk("full_pp.head",    pc_d,         32'h204);

        // Flush
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick("flush_clr");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20 + 32'(i * 4), 32'($urandom), 1'b0, 1'b0);
            tick("flush_fill");
        end
        drive(1'b1, 32'h2C, 32'h99, 1'b1, 1'b1);
        tick("flush");
        chk("flush.count",   32'(count),   32'd0);
        chk("flush.valid_d", 32'(valid_d), 32'd0);
        chk("flush.ready_f", 32'(ready_f), 32'd1);
        drive(1'b1, 32'h80, 32'hABC, 1'b0, 1'b0);
        tick("post_flush");
        chk("post_flush.pc_d", pc_d, 32'h80);
        chk("post_flush.count", 32'(count), 32'd1);

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h84, 32'hDEF, 1'b0, 1'b0);
        tick("arst_fill");
        chk("arst_pre.count", 32'(count), 32'd2);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        mq.delete();
        chk("arst.count",   32'(count),   32'd0);
        chk("arst.valid_d", 32'(valid_d), 32'd0);
        chk("arst.ready_f", 32'(ready_f), 32'd1);
        chk("arst.instr_d", instr_d,      NOP);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_model("arst_rel");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_queue
